// File: rtl/debug_pkg.sv
// Shared constants for the debug display path: digit count, blank patterns,
// and the default scan slot length.
package debug_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SCAN_DIV_DEFAULT = 100000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 8'hFF;

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to seven-segment decoder, active-low, seg[6]=a .. seg[0]=g.
module hex_to_seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        unique case (nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode display driver with decimal points,
// leading-zero blanking and one dead cycle at each digit change.
module seg_scan_driver
    import debug_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic [3:0] nibble;
    logic [6:0] seg_dec;

    // Blank when the current digit and every digit above it are zero; digit 0 always shows.
    function automatic logic lz_blank(input logic [4*NUM_DIGITS-1:0] v,
                                      input logic [IDX_W-1:0] idx);
        logic all_zero;
        all_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) >= idx && v[4*i +: 4] != 4'h0)
                all_zero = 1'b0;
        end
        return (idx != '0) && all_zero;
    endfunction

    assign nibble = shadow_val_q[{idx_q, 2'b00} +: 4];

    hex_to_seg u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_comb begin
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        an_d         = AN_OFF;
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;

        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
        end

        if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_mask;
        end

        // cnt==0 is the anti-ghosting dead slot; outputs stay dark.
        if (cnt_q != '0 && !(blank_lz && lz_blank(shadow_val_q, idx_q))) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = seg_dec;
            dp_d  = ~shadow_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-by-cycle reference model plus directed literal checks.
module tb_seg_scan_driver;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dp_mask = '0;
    logic        blank_lz = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seg_scan_driver #(.SCAN_DIV(SD)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .dp_mask  (dp_mask),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected {an,seg,dp} for the k-th cycle since reset, from display rules alone.
    function automatic logic [15:0] model_out(input int k, input logic [31:0] v,
                                              input logic [7:0] dm, input logic blz);
        int ph;
        int d;
        logic [31:0] upper;
        logic [7:0] a;
        logic [6:0] s;
        logic p;
        ph = k % SD;
        d = (k / SD) % 8;
        upper = v >> (4 * d);
        a = 8'hFF;
        s = 7'h7F;
        p = 1'b1;
        if (ph != 0 && !(blz && d != 0 && upper == 0)) begin
            a = 8'hFF & ~(8'd1 << d);
            s = SEG_TAB[upper[3:0]];
            p = ~dm[d];
        end
        return {a, s, p};
    endfunction

    int          m_k = 0;
    logic [31:0] m_v = '0;
    logic [7:0]  m_dp = '0;
    bit          m_valid = 1'b0;
    logic [15:0] exp_v;

    always @(posedge clk) begin
        if (reset) begin
            exp_v = 16'hFFFF;
            m_k = 0;
            m_v = '0;
            m_dp = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            exp_v = model_out(m_k, m_v, m_dp, blank_lz);
            m_k++;
            if (load) begin
                m_v = value;
                m_dp = dp_mask;
            end
        end
        #1;
        if (m_valid) chk("scan_model", {an, seg, dp}, exp_v);
    end

    task automatic wait_an(input logic [7:0] target, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk);
            #2;
            if (an == target) hit = 1'b1;
        end
        if (!hit) chk({name, "_timeout"}, {8'h00, an}, {8'h00, target});
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] m);
        @(negedge clk);
        value = v;
        dp_mask = m;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int bad;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state, then first dead and first active cycle of digit 0.
        @(posedge clk); #2;
        chk("first_dead", {an, seg, dp}, 16'hFFFF);
        @(posedge clk); #2;
        chk("first_active", {an, seg, dp}, {8'hFE, 7'h01, 1'b1});
        wait_an(8'h7F, "zero_d7");
        chk("zero_d7_seg", {9'h0, seg}, {9'h0, 7'h01});

        do_load(32'h89AB_CDEF, 8'h01);
        wait_an(8'hFE, "hex_d0");
        chk("hex_d0", {8'h0, seg, dp}, {8'h0, 7'b0111000, 1'b0});
        wait_an(8'h7F, "hex_d7");
        chk("hex_d7", {8'h0, seg, dp}, {8'h0, 7'b0000000, 1'b1});

        blank_lz = 1'b1;
        do_load(32'h0000_0A05, 8'h00);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (an[7:3] != 5'h1F) bad++;
        end
        chk("lz_upper_dark", 16'(bad), 16'd0);
        wait_an(8'hFB, "lz_d2");
        chk("lz_d2", {9'h0, seg}, {9'h0, 7'b0001000});
        wait_an(8'hFD, "lz_d1");
        chk("lz_d1", {9'h0, seg}, {9'h0, 7'b0000001});
        wait_an(8'hFE, "lz_d0");
        chk("lz_d0", {9'h0, seg}, {9'h0, 7'b0100100});
        @(negedge clk);
        blank_lz = 1'b0;
        wait_an(8'h7F, "nolz_d7");
        chk("nolz_d7", {9'h0, seg}, {9'h0, 7'b0000001});

        blank_lz = 1'b1;
        do_load(32'h0, 8'h80);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if ((an != 8'hFF && an != 8'hFE) || dp != 1'b1) bad++;
        end
        chk("allzero_only_d0", 16'(bad), 16'd0);
        wait_an(8'hFE, "allzero_d0");
        chk("allzero_d0", {9'h0, seg}, {9'h0, 7'b0000001});

        // Load on the cnt 3->0 wrap edge.
        @(negedge clk);
        blank_lz = 1'b0;
        do_load(32'h1111_1111, 8'h00);
        wait_an(8'hFF, "wrap_align");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        value = 32'h2222_2222;
        load = 1'b1;
        @(posedge clk); #2;
        load = 1'b0;
        chk("wrap_old", {9'h0, seg}, {9'h0, 7'b1001111});
        @(posedge clk); #2;
        chk("wrap_dead", {an, seg, dp}, 16'hFFFF);
        @(posedge clk); #2;
        chk("wrap_new", {9'h0, seg}, {9'h0, 7'b0010010});

        // Reset in the middle of digit 5.
        wait_an(8'hDF, "rst_d5");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_vals", {an, seg, dp}, 16'hFFFF);
        @(posedge clk); #2;
        chk("rst_dead", {an, seg, dp}, 16'hFFFF);
        @(posedge clk); #2;
        chk("rst_resume", {an, seg, dp}, {8'hFE, 7'h01, 1'b1});

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            load = ($urandom % 6) == 0;
            value = $urandom >> ($urandom % 33);
            dp_mask = 8'($urandom);
            if ($urandom % 16 == 0) blank_lz = ~blank_lz;
            reset = ($urandom % 250) == 0;
        end
        @(negedge clk);
        load = 1'b0;
        reset = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
